// File: rtl/axi_stream_strip_header.sv
// rtl/axi_stream_strip_header.sv - strips an H-byte header from each AXI Stream packet and realigns the payload MSB-first
// Optional `AXIS_STRIP_OUT_SKID_EN: 2-entry payload skid buffer, removing the ready_out -> ready_in path.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic                    err_short
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HEAD  = 2'd1;
  localparam logic [1:0] S_BODY  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Byte counts are kept wide enough to hold R+k, which can exceed one beat.
  localparam int NW = BYTE_CNT_WD + 2;
  localparam logic [NW-1:0] LP_NB = NW'(DATA_BYTE_WD);

  function automatic logic [DATA_BYTE_WD-1:0] f_top(input logic [NW-1:0] n);
    f_top = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) f_top[i] = (i >= DATA_BYTE_WD - int'(n));
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] f_low(input logic [NW-1:0] n);
    f_low = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) f_low[i] = (i < int'(n));
  endfunction

  logic [1:0]              r_state;
  logic [BYTE_CNT_WD-1:0]  r_hcnt;
  logic [DATA_WD-1:0]      r_res;
  logic [NW-1:0]           r_res_cnt;
  logic                    r_valid_header;
  logic [DATA_WD-1:0]      r_data_header;
  logic [DATA_BYTE_WD-1:0] r_keep_header;
  logic                    r_err;

  logic [NW-1:0]           w_h, w_r, w_k, w_hdr_n, w_res_cnt_nxt;
  logic [DATA_WD-1:0]      w_din, w_res_nxt, w_beat_data, w_hdr_data;
  logic [DATA_BYTE_WD-1:0] w_beat_keep, w_hdr_keep;
  logic [1:0]              w_state_nxt;
  logic                    w_beat_vld, w_beat_last, w_hdr_load, w_res_load, w_err;
  logic                    w_pay_free, w_in_fire;

  assign w_h = NW'(r_hcnt) + NW'(1);
  assign w_r = LP_NB - w_h;

  // Lanes outside keep_in are zeroed so stale bytes never leak into output beats.
  always_comb begin
    w_k   = '0;
    w_din = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_k = w_k + NW'(keep_in[i]);
      w_din[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
    end
  end

  assign ready_strip = (r_state == S_IDLE);
  assign ready_in    = (r_state == S_HEAD) ? ((!r_valid_header || ready_header) && w_pay_free) :
                       (r_state == S_BODY) ? w_pay_free : 1'b0;
  assign w_in_fire   = valid_in && ready_in;

  always_comb begin
    w_state_nxt   = r_state;
    w_beat_vld    = 1'b0;
    w_beat_data   = '0;
    w_beat_keep   = '0;
    w_beat_last   = 1'b0;
    w_hdr_load    = 1'b0;
    w_hdr_n       = w_h;
    w_res_load    = 1'b0;
    w_res_nxt     = '0;
    w_res_cnt_nxt = r_res_cnt;
    w_err         = 1'b0;
    case (r_state)
      S_IDLE: if (valid_strip) w_state_nxt = S_HEAD;
      S_HEAD: if (w_in_fire) begin
        w_hdr_load    = 1'b1;
        w_hdr_n       = (w_k < w_h) ? w_k : w_h;
        w_res_load    = 1'b1;
        w_res_nxt     = w_din << {w_h, 3'b000};
        w_res_cnt_nxt = w_r;
        if (!last_in) begin
          w_state_nxt = S_BODY;
        end else begin
          w_state_nxt = S_IDLE;
          w_err       = (w_k < w_h);
          if (w_k > w_h) begin
            w_beat_vld  = 1'b1;
            w_beat_data = w_din << {w_h, 3'b000};
            w_beat_keep = f_top(w_k - w_h);
            w_beat_last = 1'b1;
          end
        end
      end
      S_BODY: if (w_in_fire) begin
        w_beat_vld    = 1'b1;
        w_beat_data   = r_res | (w_din >> {w_r, 3'b000});
        w_beat_keep   = '1;
        w_res_load    = 1'b1;
        w_res_nxt     = w_din << {w_h, 3'b000};
        w_res_cnt_nxt = w_r;
        if (last_in) begin
          if (w_r + w_k <= LP_NB) begin
            w_beat_keep = f_top(w_r + w_k);
            w_beat_last = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_res_cnt_nxt = w_k - w_h;
            w_state_nxt   = S_FLUSH;
          end
        end
      end
      S_FLUSH: if (w_pay_free) begin
        w_beat_vld  = 1'b1;
        w_beat_data = r_res;
        w_beat_keep = f_top(r_res_cnt);
        w_beat_last = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A short packet carries only k header bytes, still right-aligned.
  assign w_hdr_data = w_din >> {LP_NB - w_hdr_n, 3'b000};
  assign w_hdr_keep = f_low(w_hdr_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_hcnt         <= '0;
      r_res          <= '0;
      r_res_cnt      <= '0;
      r_valid_header <= 1'b0;
      r_data_header  <= '0;
      r_keep_header  <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (ready_strip && valid_strip) r_hcnt <= byte_strip_cnt;
      if (w_res_load) begin
        r_res     <= w_res_nxt;
        r_res_cnt <= w_res_cnt_nxt;
      end
      if (w_hdr_load) begin
        r_valid_header <= 1'b1;
        r_data_header  <= w_hdr_data;
        r_keep_header  <= w_hdr_keep;
      end else if (ready_header) begin
        r_valid_header <= 1'b0;
      end
    end
  end

  assign valid_header = r_valid_header;
  assign data_header  = r_data_header;
  assign keep_header  = r_keep_header;
  assign err_short    = r_err;

`ifdef AXIS_STRIP_OUT_SKID_EN
  localparam int QW = DATA_WD + DATA_BYTE_WD + 1;
  logic [QW-1:0] r_q0, r_q1;
  logic [1:0]    r_qcnt;
  logic [QW-1:0] w_beat_q;
  logic          w_pop;

  // Space is judged from the registered fill level only, so ready_in never sees ready_out.
  assign w_pay_free = (r_qcnt != 2'd2);
  assign w_beat_q   = {w_beat_last, w_beat_keep, w_beat_data};
  assign w_pop      = (r_qcnt != 2'd0) && ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q0   <= '0;
      r_q1   <= '0;
      r_qcnt <= 2'd0;
    end else begin
      case ({w_beat_vld, w_pop})
        2'b10: begin
          if (r_qcnt == 2'd0) r_q0 <= w_beat_q;
          else                r_q1 <= w_beat_q;
          r_qcnt <= r_qcnt + 2'd1;
        end
        2'b01: begin
          r_q0   <= r_q1;
          r_qcnt <= r_qcnt - 2'd1;
        end
        2'b11: r_q0 <= w_beat_q;
        default: ;
      endcase
    end
  end

  assign valid_out = (r_qcnt != 2'd0);
  assign data_out  = r_q0[DATA_WD-1:0];
  assign keep_out  = r_q0[DATA_WD +: DATA_BYTE_WD];
  assign last_out  = r_q0[QW-1];
`else
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;

  assign w_pay_free = !r_valid_out || ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else if (w_beat_vld) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_beat_data;
      r_keep_out  <= w_beat_keep;
      r_last_out  <= w_beat_last;
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign keep_out  = r_keep_out;
  assign last_out  = r_last_out;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb/tb_axi_stream_strip_header.sv - scoreboard bench for axi_stream_strip_header
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_strip = 1'b0;
  logic [1:0]  byte_strip_cnt = '0;
  logic        ready_strip;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        ready_header = 1'b1;
  logic        err_short;

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header), .ready_header(ready_header),
    .err_short(err_short)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_pay[$];
  beat_t       exp_hdr[$];
  logic [7:0]  pkt[$];
  int          checks = 0;
  int          errors = 0;
  int          err_exp = 0;
  int          err_seen = 0;
  bit          mon_en = 1'b0;
  bit          bp_en = 1'b0;

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Output monitor: stability while stalled, and scoreboard pops on each handshake.
  bit    hold_p = 1'b0, hold_h = 1'b0;
  beat_t last_p, last_h, mon_e;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      hold_p = 1'b0;
      hold_h = 1'b0;
    end else begin
      if (err_short === 1'b1) err_seen++;
      if (hold_p) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== last_p.d || keep_out !== last_p.k || last_out !== last_p.l) begin
          errors++;
          $display("FAIL payload_hold: got v=%0b d=%h k=%h l=%0b, need v=1 d=%h k=%h l=%0b",
                   valid_out, data_out, keep_out, last_out, last_p.d, last_p.k, last_p.l);
        end
      end
      if (hold_h) begin
        checks++;
        if (valid_header !== 1'b1 || data_header !== last_h.d || keep_header !== last_h.k) begin
          errors++;
          $display("FAIL header_hold: got v=%0b d=%h k=%h, need v=1 d=%h k=%h",
                   valid_header, data_header, keep_header, last_h.d, last_h.k);
        end
      end
      if (valid_out && ready_out) begin
        checks++;
        if (exp_pay.size() == 0) begin
          errors++;
          $display("FAIL payload_extra: got d=%h k=%h l=%0b, need no beat", data_out, keep_out, last_out);
        end else begin
          mon_e = exp_pay.pop_front();
          if ((data_out & kmask(keep_out)) !== mon_e.d || keep_out !== mon_e.k || last_out !== mon_e.l) begin
            errors++;
            $display("FAIL payload_beat: got d=%h k=%h l=%0b, need d=%h k=%h l=%0b",
                     data_out & kmask(keep_out), keep_out, last_out, mon_e.d, mon_e.k, mon_e.l);
          end
        end
      end
      if (valid_header && ready_header) begin
        checks++;
        if (exp_hdr.size() == 0) begin
          errors++;
          $display("FAIL header_extra: got d=%h k=%h, need no header", data_header, keep_header);
        end else begin
          mon_e = exp_hdr.pop_front();
          if ((data_header & kmask(keep_header)) !== mon_e.d || keep_header !== mon_e.k) begin
            errors++;
            $display("FAIL header_word: got d=%h k=%h, need d=%h k=%h",
                     data_header & kmask(keep_header), keep_header, mon_e.d, mon_e.k);
          end
        end
      end
      hold_p = valid_out && !ready_out;
      last_p = '{d: data_out, k: keep_out, l: last_out};
      hold_h = valid_header && !ready_header;
      last_h = '{d: data_header, k: keep_header, l: 1'b0};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        ready_out    = ($urandom_range(0, 3) != 0);
        ready_header = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_word(input logic [31:0] w, input int nbytes);
    for (int i = 0; i < nbytes; i++) pkt.push_back(w[31-8*i -: 8]);
  endtask

  task automatic make_pkt(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  // Reference: header = first min(H,n) bytes right-aligned; payload = the rest, packed MSB-first.
  task automatic push_expect(input logic [1:0] c);
    int    h, n, hn, np;
    beat_t e;
    h  = int'(c) + 1;
    n  = pkt.size();
    hn = (n < h) ? n : h;
    e.d = '0;
    for (int i = 0; i < hn; i++) e.d = {e.d[23:0], pkt[i]};
    e.k = 4'((1 << hn) - 1);
    e.l = 1'b0;
    exp_hdr.push_back(e);
    if (n < h) err_exp++;
    np = (n > h) ? n - h : 0;
    for (int s = 0; s < np; s += 4) begin
      e.d = '0;
      e.k = '0;
      for (int j = 0; j < 4; j++) begin
        e.d = {e.d[23:0], (s + j < np) ? pkt[h + s + j] : 8'h00};
        e.k = {e.k[2:0], (s + j < np)};
      end
      e.l = (s + 4 >= np);
      exp_pay.push_back(e);
    end
  endtask

  task automatic do_strip(input logic [1:0] c);
    int n;
    n = 0;
    valid_strip    = 1'b1;
    byte_strip_cnt = c;
    forever begin
      @(negedge clk);
      if (ready_strip) break;
      if (++n > 500) begin
        checks++;
        errors++;
        $display("FAIL strip_timeout: got ready_strip=0 for %0d cycles, need 1", n);
        break;
      end
    end
    tick();
    valid_strip = 1'b0;
  endtask

  task automatic send_beats(input int max_beats);
    int nb, n, cnt;
    nb  = pkt.size();
    cnt = 0;
    for (int s = 0; s < nb && cnt < max_beats; s += 4) begin
      if (bp_en) repeat ($urandom_range(0, 2)) tick();
      valid_in = 1'b1;
      data_in  = '0;
      keep_in  = '0;
      for (int j = 0; j < 4; j++) begin
        data_in = {data_in[23:0], (s + j < nb) ? pkt[s + j] : 8'h00};
        keep_in = {keep_in[2:0], (s + j < nb)};
      end
      last_in = (s + 4 >= nb);
      n = 0;
      forever begin
        @(negedge clk);
        if (ready_in) break;
        if (++n > 500) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout: got ready_in=0 for %0d cycles, need 1", n);
          break;
        end
      end
      tick();
      valid_in = 1'b0;
      last_in  = 1'b0;
      cnt++;
    end
  endtask

  task automatic send_pkt(input logic [1:0] c);
    do_strip(c);
    push_expect(c);
    send_beats(1000);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0 || valid_out || valid_header) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain: got %0d payload and %0d header entries outstanding, need 0", exp_pay.size(), exp_hdr.size());
    end
    checks++;
    if (err_seen !== err_exp) begin
      errors++;
      $display("FAIL err_short_count: got %0d pulse cycles, need %0d", err_seen, err_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks += 9;
    if (ready_strip !== 1'b1) begin errors++; $display("FAIL rst_ready_strip: got %0b need 1", ready_strip); end
    if (ready_in !== 1'b0) begin errors++; $display("FAIL rst_ready_in: got %0b need 0", ready_in); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out: got %0b need 0", valid_out); end
    if (valid_header !== 1'b0) begin errors++; $display("FAIL rst_valid_header: got %0b need 0", valid_header); end
    if (err_short !== 1'b0) begin errors++; $display("FAIL rst_err_short: got %0b need 0", err_short); end
    if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out: got %h need 0", data_out); end
    if (keep_out !== 4'h0) begin errors++; $display("FAIL rst_keep_out: got %h need 0", keep_out); end
    if (last_out !== 1'b0) begin errors++; $display("FAIL rst_last_out: got %0b need 0", last_out); end
    if (data_header !== 32'h0) begin errors++; $display("FAIL rst_data_header: got %h need 0", data_header); end
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_directed();
    pkt.delete();
    add_word(32'hAABBCCDD, 4); add_word(32'h11223344, 4); add_word(32'h55660000, 2);
    send_pkt(2'd1);
    pkt.delete();
    add_word(32'h01020304, 4); add_word(32'h05060700, 3);
    send_pkt(2'd0);
    pkt.delete();
    add_word(32'h10111213, 4); add_word(32'h20212223, 4); add_word(32'h30313233, 4);
    send_pkt(2'd3);
    drain();
  endtask

  task automatic test_err_short();
    pkt.delete();
    add_word(32'hA1A20000, 2);
    send_pkt(2'd2);
    checks += 2;
    if (ready_strip !== 1'b1) begin errors++; $display("FAIL short_ready_strip: got %0b need 1", ready_strip); end
    if (err_short !== 1'b1) begin errors++; $display("FAIL short_pulse_on: got %0b need 1", err_short); end
    tick();
    checks++;
    if (err_short !== 1'b0) begin errors++; $display("FAIL short_pulse_off: got %0b need 0", err_short); end
    drain();
  endtask

  task automatic test_header_stall();
    ready_header = 1'b0;
    make_pkt(6);
    send_pkt(2'd1);
    make_pkt(5);
    do_strip(2'd0);
    push_expect(2'd0);
    valid_in = 1'b1;
    data_in  = {pkt[0], pkt[1], pkt[2], pkt[3]};
    keep_in  = 4'hF;
    last_in  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (ready_in !== 1'b0) begin errors++; $display("FAIL hdr_stall_ready_in: got %0b need 0", ready_in); end
      tick();
    end
    valid_in     = 1'b0;
    ready_header = 1'b1;
    send_beats(1000);
    drain();
  endtask

  task automatic test_payload_stall();
    make_pkt(20);
    fork
      send_pkt(2'd1);
    join_none
    for (int n = 0; n < 200 && !valid_out; n++) @(negedge clk);
    tick();
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1) begin errors++; $display("FAIL pay_stall_valid: got %0b need 1", valid_out); end
      if (i >= 2) begin
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("FAIL pay_stall_ready_in: got %0b need 0", ready_in); end
      end
      tick();
    end
    ready_out = 1'b1;
    wait fork;
    drain();
  endtask

  task automatic test_random();
    bp_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      make_pkt($urandom_range(1, 14));
      send_pkt(2'($urandom_range(0, 3)));
    end
    bp_en = 1'b0;
    tick();
    ready_out    = 1'b1;
    ready_header = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    make_pkt(12);
    do_strip(2'd1);
    send_beats(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_rst_valid_out: got %0b need 0", valid_out); end
    if (valid_header !== 1'b0) begin errors++; $display("FAIL mid_rst_valid_header: got %0b need 0", valid_header); end
    if (ready_in !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_in: got %0b need 0", ready_in); end
    if (ready_strip !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_strip: got %0b need 1", ready_strip); end
    exp_pay.delete();
    exp_hdr.delete();
    tick();
    mon_en = 1'b1;
    make_pkt(9);
    send_pkt(2'd2);
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err_short();
    test_header_stall();
    test_payload_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion by time limit, need finish");
    $fatal(1);
  end

endmodule
